// File: rtl/viterbi_decoder_k3.sv
// Hard-decision Viterbi decoder for the K=3, rate-1/2 (7,5) code: 4-state ACS
// with register-exchange survivors; each bit leaves TB_DEPTH-1 symbols after it arrived.
module viterbi_decoder_k3 #(
    parameter int TB_DEPTH = 16,
    parameter int PM_W     = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            restart,
    input  logic            in_valid,
    input  logic [1:0]      in_symbol,
    output logic            out_valid,
    output logic            decoded_bit,
    output logic [PM_W-1:0] metric_out
);
    localparam int CNT_W = $clog2(TB_DEPTH);
    localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(TB_DEPTH - 1);
    localparam logic [PM_W:0]    NORM     = {2'b01, {(PM_W-1){1'b0}}};
    localparam logic [PM_W-1:0]  PM_START = PM_W'(4);

    logic [PM_W-1:0]     pm       [4];
    logic [TB_DEPTH-2:0] path     [4];
    logic [CNT_W-1:0]    fill;
    logic [PM_W:0]       pm_raw   [4];
    logic [PM_W-1:0]     pm_new   [4];
    logic [TB_DEPTH-1:0] path_new [4];
    logic [1:0]          best;
    logic                norm;

    logic [1:0]  nxt, p0, p1, exp0, exp1;
    logic [1:0]  bm0, bm1;
    logic [PM_W:0] cand0, cand1;

    function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] d;
        d = a ^ b;
        return {1'b0, d[1]} + {1'b0, d[0]};
    endfunction

    always_comb begin
        // NOTE: every variable gets a value before any branch so no latch is inferred.
        nxt   = '0;
        p0    = '0;
        p1    = '0;
        exp0  = '0;
        exp1  = '0;
        bm0   = '0;
        bm1   = '0;
        cand0 = '0;
        cand1 = '0;
        norm  = 1'b1;
        best  = '0;
        for (int i = 0; i < 4; i++) begin
            // Next state {u,a}; predecessors {a,0} and {a,1}.
            nxt   = 2'(i);
            p0    = {nxt[0], 1'b0};
            p1    = {nxt[0], 1'b1};
            exp0  = {nxt[1] ^ nxt[0], nxt[1]};
            exp1  = {~(nxt[1] ^ nxt[0]), ~nxt[1]};
            bm0   = hamming2(in_symbol, exp0);
            bm1   = hamming2(in_symbol, exp1);
            cand0 = {1'b0, pm[p0]} + {{(PM_W-1){1'b0}}, bm0};
            cand1 = {1'b0, pm[p1]} + {{(PM_W-1){1'b0}}, bm1};
            if (cand1 < cand0) begin
                pm_raw[i]   = cand1;
                path_new[i] = {path[p1], nxt[1]};
            end else begin
                pm_raw[i]   = cand0;
                path_new[i] = {path[p0], nxt[1]};
            end
            norm = norm & (pm_raw[i] >= NORM);
        end
        for (int i = 0; i < 4; i++)
            pm_new[i] = PM_W'(norm ? pm_raw[i] - NORM : pm_raw[i]);
        for (int i = 1; i < 4; i++)
            if (pm_new[i] < pm_new[best]) best = 2'(i);
    end

    // Only TB_DEPTH-1 survivor bits are stored; the oldest bit of each new path
    // exists only combinationally, long enough to be emitted.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst) begin
            // NOTE: survivors are plain flops, so they are cleared like any other state.
            pm          <= '{'0, PM_START, PM_START, PM_START};
            path        <= '{default: '0};
            fill        <= '0;
            out_valid   <= 1'b0;
            decoded_bit <= 1'b0;
            metric_out  <= '0;
        end else if (restart) begin
            pm          <= '{'0, PM_START, PM_START, PM_START};
            path        <= '{default: '0};
            fill        <= '0;
            out_valid   <= 1'b0;
            decoded_bit <= 1'b0;
            metric_out  <= '0;
        end else if (in_valid) begin
            pm <= pm_new;
            for (int i = 0; i < 4; i++)
                path[i] <= path_new[i][TB_DEPTH-2:0];
            fill        <= (fill == FILL_MAX) ? fill : fill + CNT_W'(1);
            out_valid   <= (fill == FILL_MAX);
            decoded_bit <= path_new[best][TB_DEPTH-1];
            metric_out  <= pm_new[best];
        end else begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_viterbi_decoder_k3.sv
// Self-checking bench for viterbi_decoder_k3: directed frames plus randomized noisy
// frames compared cycle by cycle against a full-history Viterbi model.
module tb_viterbi_decoder_k3;
    localparam int TB_DEPTH = 16;
    localparam int PM_W     = 6;
    localparam int MAXN     = 512;

    logic            clk = 1'b0;
    logic            rst;
    logic            restart;
    logic            in_valid;
    logic [1:0]      in_symbol;
    logic            out_valid;
    logic            decoded_bit;
    logic [PM_W-1:0] metric_out;

    viterbi_decoder_k3 #(.TB_DEPTH(TB_DEPTH), .PM_W(PM_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .restart    (restart),
        .in_valid   (in_valid),
        .in_symbol  (in_symbol),
        .out_valid  (out_valid),
        .decoded_bit(decoded_bit),
        .metric_out (metric_out)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: integer metrics and the complete decision history per state.
    int m_pm [4];
    bit m_hist [4][MAXN];
    int m_n;
    bit e_ov, e_db;
    int e_mo;

    task automatic model_reset();
        m_pm = '{0, 4, 4, 4};
        m_n  = 0;
        e_ov = 0;
        e_db = 0;
        e_mo = 0;
    endtask

    task automatic model_accept(input logic [1:0] sym);
        int npm [4];
        bit nh [4][MAXN];
        int bestc, bp, c, bm, bs;
        bit u, a, c1, c0, all_big;
        for (int ns = 0; ns < 4; ns++) begin
            u = bit'(ns / 2);
            a = bit'(ns % 2);
            bestc = -1;
            bp = 0;
            for (int b = 0; b < 2; b++) begin
                c1 = u ^ a ^ bit'(b);
                c0 = u ^ bit'(b);
                bm = int'(sym[1] != c1) + int'(sym[0] != c0);
                c  = m_pm[2 * a + b] + bm;
                if (b == 0 || c < bestc) begin
                    bestc = c;
                    bp = 2 * a + b;
                end
            end
            npm[ns] = bestc;
            for (int k = 0; k < m_n; k++) nh[ns][k] = m_hist[bp][k];
            nh[ns][m_n] = u;
        end
        all_big = 1;
        for (int s = 0; s < 4; s++) if (npm[s] < 32) all_big = 0;
        if (all_big) for (int s = 0; s < 4; s++) npm[s] -= 32;
        bs = 0;
        for (int s = 1; s < 4; s++) if (npm[s] < npm[bs]) bs = s;
        e_ov = (m_n >= TB_DEPTH - 1);
        e_db = e_ov ? nh[bs][m_n - (TB_DEPTH - 1)] : 1'b0;
        e_mo = npm[bs];
        m_pm = npm;
        m_hist = nh;
        if (m_n < MAXN - 1) m_n++;
    endtask

    // Per-frame observations of the DUT, judged against constants after each frame.
    bit          got_bits [$];
    int          mo_log   [$];
    int          acc_cnt, first_pulse, gap_pulses;
    bit          tx_data  [$];
    logic [1:0]  tx_syms  [$];

    task automatic clear_logs();
        got_bits.delete();
        mo_log.delete();
        acc_cnt = 0;
        first_pulse = -1;
        gap_pulses = 0;
    endtask

    function automatic int got_bit_at(input int i);
        return (i < got_bits.size()) ? int'(got_bits[i]) : 2;
    endfunction

    task automatic drive(input bit v, input bit rs, input logic [1:0] sym);
        @(negedge clk);
        in_valid  = v;
        restart   = rs;
        in_symbol = sym;
        @(posedge clk);
        #1;
        if (rs) begin
            model_reset();
            clear_logs();
        end else if (v) begin
            model_accept(sym);
        end else begin
            e_ov = 0;
        end
        check("out_valid", out_valid, e_ov);
        check("decoded_bit", decoded_bit, e_db);
        check("metric_out", metric_out, e_mo);
        if (!rs && !v && out_valid) gap_pulses++;
        if (!rs && v) begin
            mo_log.push_back(int'(metric_out));
            if (out_valid) begin
                got_bits.push_back(decoded_bit);
                if (first_pulse < 0) first_pulse = acc_cnt;
            end
            acc_cnt++;
        end
    endtask

    task automatic build_syms();
        bit u1, u2;
        u1 = 0;
        u2 = 0;
        tx_syms.delete();
        foreach (tx_data[i]) begin
            tx_syms.push_back({tx_data[i] ^ u1 ^ u2, tx_data[i] ^ u2});
            u2 = u1;
            u1 = tx_data[i];
        end
    endtask

    task automatic run_stream(input int gap_pct);
        foreach (tx_syms[i]) begin
            while ($urandom_range(99) < gap_pct) drive(1'b0, 1'b0, 2'($urandom));
            drive(1'b1, 1'b0, tx_syms[i]);
        end
    endtask

    task automatic load_clean();
        logic [1:0] six [6];
        six = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
        tx_syms.delete();
        for (int i = 0; i < 6; i++) tx_syms.push_back(six[i]);
        for (int i = 0; i < TB_DEPTH - 1; i++) tx_syms.push_back(2'b00);
    endtask

    task automatic check_clean_bits(input string tag);
        bit exp6 [6];
        exp6 = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        check({tag, "_count"}, got_bits.size(), 6);
        check({tag, "_first"}, first_pulse, TB_DEPTH - 1);
        for (int i = 0; i < 6; i++) check({tag, "_bit"}, got_bit_at(i), int'(exp6[i]));
    endtask

    function automatic int max_metric(input int from);
        int m;
        m = 0;
        for (int i = from; i < mo_log.size(); i++) if (mo_log[i] > m) m = mo_log[i];
        return m;
    endfunction

    initial begin
        int ones, errs, len, gaps_frame;
        rst = 1'b0;
        restart = 1'b0;
        in_valid = 1'b0;
        in_symbol = 2'b00;
        model_reset();
        clear_logs();
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_decoded_bit", decoded_bit, 0);
        check("reset_metric_out", metric_out, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) drive(1'b0, 1'b0, 2'b11);

        // All-zero stream.
        clear_logs();
        tx_data.delete();
        for (int i = 0; i < 40; i++) tx_data.push_back(1'b0);
        build_syms();
        run_stream(0);
        ones = 0;
        foreach (got_bits[i]) ones += int'(got_bits[i]);
        check("zeros_first_pulse", first_pulse, TB_DEPTH - 1);
        check("zeros_pulses", got_bits.size(), 40 - (TB_DEPTH - 1));
        check("zeros_ones", ones, 0);
        check("zeros_max_metric", max_metric(0), 0);

        // Clean known stream.
        drive(1'b0, 1'b1, 2'b00);
        load_clean();
        run_stream(0);
        check_clean_bits("clean");
        check("clean_max_metric", max_metric(0), 0);

        // Third symbol corrupted.
        drive(1'b0, 1'b1, 2'b00);
        load_clean();
        tx_syms[2] = 2'b10;
        run_stream(0);
        check_clean_bits("corrupt");
        check("corrupt_metric_sym1", mo_log[1], 0);
        check("corrupt_metric_sym2", mo_log[2], 1);
        check("corrupt_metric_last", mo_log[mo_log.size() - 1], 1);
        check("corrupt_metric_max", max_metric(2), 1);

        // Random idle gaps.
        drive(1'b0, 1'b1, 2'b00);
        load_clean();
        run_stream(40);
        check_clean_bits("gaps");
        check("gaps_pulses_in_gap", gap_pulses, 0);

        // Restart mid-frame together with a valid symbol, then replay.
        drive(1'b0, 1'b1, 2'b00);
        load_clean();
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, tx_syms[i]);
        drive(1'b1, 1'b1, 2'b11);
        run_stream(0);
        check_clean_bits("restart");

        // Asynchronous reset between clock edges.
        drive(1'b0, 1'b1, 2'b00);
        load_clean();
        tx_syms[2] = 2'b10;
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, tx_syms[i]);
        check("pre_async_metric", metric_out, 1);
        @(negedge clk);
        in_valid = 1'b0;
        restart = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("async_out_valid", out_valid, 0);
        check("async_decoded_bit", decoded_bit, 0);
        check("async_metric_out", metric_out, 0);
        model_reset();
        clear_logs();
        #1 rst = 1'b1;
        load_clean();
        run_stream(0);
        check_clean_bits("after_async");

        // Randomized noisy frames against the model; the noisiest drives normalisation.
        for (int f = 0; f < 4; f++) begin
            int flip_pct [4];
            flip_pct = '{0, 3, 10, 50};
            drive(1'b0, 1'b1, 2'b00);
            len = 150 + int'($urandom_range(150));
            tx_data.delete();
            for (int i = 0; i < len; i++) tx_data.push_back(1'($urandom));
            for (int i = 0; i < TB_DEPTH - 1; i++) tx_data.push_back(1'b0);
            build_syms();
            foreach (tx_syms[i]) begin
                if ($urandom_range(99) < flip_pct[f]) tx_syms[i][0] = ~tx_syms[i][0];
                if ($urandom_range(99) < flip_pct[f]) tx_syms[i][1] = ~tx_syms[i][1];
            end
            gaps_frame = 20;
            run_stream(gaps_frame);
            check("rand_pulses", got_bits.size(), len);
            check("rand_gap_pulses", gap_pulses, 0);
            if (f == 0) begin
                errs = 0;
                for (int i = 0; i < len; i++) if (got_bit_at(i) != int'(tx_data[i])) errs++;
                check("rand_clean_bit_errors", errs, 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/viterbi_decoder_k3.md
# viterbi_decoder_k3

Hard-decision Viterbi decoder for the rate-1/2, constraint-length-3 convolutional code (generators 7/5 octal) produced by our K=3 encoder. It sits at the receive end of the encoder/decoder link. It accepts one 2-bit code symbol per valid cycle and emits one decoded data bit per accepted symbol after a fixed traceback delay. It uses 4-state add-compare-select and register-exchange survivor memory.

## Interface
- TB_DEPTH, 16: survivor path length in bits, and the decode delay in symbols; ≥ 5.
- PM_W, 6: path-metric width; ≥ 4.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- restart  in  1  synchronous re-initialisation to the reset state; used at a frame start.
- in_valid  in  1  in_symbol is valid this cycle.
- in_symbol  in  2  received symbol {c1,c0}, where c1 = u^u[-1]^u[-2] and c0 = u^u[-2].
- out_valid  out  1  one-cycle pulse; decoded_bit is valid.
- decoded_bit  out  1  decoded data bit.
- metric_out  out  PM_W  best path metric after the latest accepted symbol.

## Operation
- Trellis state s = {u[-1], u[-2]}, indices 0..3.
  - From state {a,b}, input u leads to next state {u,a}.
  - Expected symbol on that branch is {u^a^b, u^b}.
  - Next state {u,a} has predecessors {a,0} and {a,1}.
- Branch metric = Hamming distance between in_symbol and the expected symbol (0..2).
- ACS, once per accepted symbol (in_valid=1, restart=0), for each next state:
  - cand0 = PM[{a,0}] + bm0 and cand1 = PM[{a,1}] + bm1, computed at PM_W+1 bits.
  - Select the smaller. On a tie, select predecessor {a,0}.
- Normalisation: if every new metric is ≥ 2^(PM_W-1), subtract 2^(PM_W-1) from all four. The results then fit in PM_W bits, because metric spread is ≤ 4.
- Survivors: path[{u,a}] <= {path[selected pred][TB_DEPTH-2:0], u}.
- Best state = the minimum new metric; ties go to the lowest index.
  - decoded_bit <= path_new[best][TB_DEPTH-1].
  - metric_out <= new metric of the best state.
- Fill counter counts accepted symbols and saturates at TB_DEPTH-1. out_valid pulses on every accepted symbol once the counter has reached TB_DEPTH-1 before that symbol's edge.
- Cycles with in_valid=0: all state is held, out_valid=0, decoded_bit and metric_out hold their values.
- Reset (rst=0, async) and restart=1 (sync) have the same effect:
  - PM = {0, 4, 4, 4} for states 0..3 (the encoder starts in state 0).
  - All paths = 0, fill counter = 0.
  - out_valid = 0, decoded_bit = 0, metric_out = 0.
- restart with in_valid in the same cycle: restart wins and the symbol is discarded.
- Reset mid-stream: the partially decoded frame is lost and no further out_valid occurs until the fill completes again.
- Draining: the source appends TB_DEPTH-1 extra symbols (encoder flushed with zeros) to release the final data bits.

## Timing
- Throughput: one symbol per clock, no backpressure.
- Latency: when symbol n (0-indexed from reset/restart) is accepted at edge n, out_valid and decoded_bit = û(n-TB_DEPTH+1) are registered on that same edge.
- The first out_valid occurs at accepted symbol TB_DEPTH-1 and carries û(0).
- metric_out updates on the edge of every accepted symbol, including symbols accepted during fill.
- All outputs are registered; no combinational input-to-output path.

## Test plan
- After reset, check outputs with no stimulus -> out_valid=0, decoded_bit=0, metric_out=0.
- Feed 40 symbols 00 -> first out_valid at symbol 15 (TB_DEPTH=16); 25 pulses, all decoded_bit=0; metric_out=0 throughout.
- Data 1,0,1,1,0,0 encoded as symbols 11,10,00,01,01,11, followed by 15 symbols 00 -> decoded bits 1,0,1,1,0,0,0… in order; metric_out=0.
- Same stream with the third symbol corrupted to 10:
  - decoded bits unchanged;
  - metric_out=1 from the third accepted symbol onward.
- Same stream with in_valid low for random gaps -> identical decoded sequence; out_valid=0 in every gap cycle.
- Assert restart mid-frame together with in_valid, then replay the stream ->
  - the restart-cycle symbol is dropped;
  - the next out_valid comes 16 accepted symbols after restart;
  - output equals the first run.
- Assert rst asynchronously between clock edges -> all outputs read 0 immediately, with no clock edge required.
